// File: rtl/onehot_codec_pipe.sv
// Two-stage valid/ready pipeline converting binary <-> one-hot per word, with a saturating error counter.
// Build option ONEHOT_CODEC_STRICT_EN: multi-hot encode inputs are flagged as errors instead of priority-encoded.
module onehot_codec_pipe #(
  parameter  int unsigned W  = 3,
  parameter  int unsigned CW = 16,
  localparam int unsigned N  = 2 ** W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_err,
  input  logic          err_clr,
  output logic [CW-1:0] err_count
);

  logic          s1_valid_q, s1_valid_d;
  logic          s1_mode_q, s1_mode_d;
  logic [N-1:0]  s1_data_q, s1_data_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_err_q, out_err_d;
  logic [CW-1:0] err_count_q, err_count_d;

  logic          in_xfer_c;
  logic          out_xfer_c;
  logic          s2_load_c;
  logic [W-1:0]  hi_idx_c;
  logic          zero_c;
  logic [N-1:0]  res_data_c;
  logic          res_err_c;
`ifdef ONEHOT_CODEC_STRICT_EN
  logic          multi_hot_c;
`endif

  // S2 may take a new word whenever it is empty or being drained this cycle.
  assign s2_load_c  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s2_load_c;
  assign in_xfer_c  = in_valid && in_ready;
  assign out_xfer_c = out_valid_q && out_ready;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign err_count  = err_count_q;

  // Highest set index; later iterations overwrite earlier ones.
  always_comb begin
    hi_idx_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (s1_data_q[i]) hi_idx_c = W'(i);
    end
  end

  assign zero_c = ~|s1_data_q;
`ifdef ONEHOT_CODEC_STRICT_EN
  assign multi_hot_c = |(s1_data_q & (s1_data_q - N'(1)));
`endif

  // Result computed from the S1 word, captured into S2 on s2_load_c.
  always_comb begin
    res_data_c = '0;
    res_err_c  = 1'b0;
    if (!s1_mode_q) begin
      res_data_c = N'(1) << s1_data_q[W-1:0];
    end else if (zero_c) begin
      res_err_c  = 1'b1;
`ifdef ONEHOT_CODEC_STRICT_EN
    end else if (multi_hot_c) begin
      res_err_c  = 1'b1;
`endif
    end else begin
      res_data_c = N'(hi_idx_c);
    end
  end

  // Next-state for both stages and the error counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;

    if (in_xfer_c) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = in_mode;
      s1_data_d  = in_data;
    end else if (s2_load_c) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load_c) begin
      out_valid_d = 1'b1;
      out_data_d  = res_data_c;
      out_err_d   = res_err_c;
    end else if (out_xfer_c) begin
      out_valid_d = 1'b0;
    end

    // Clear takes priority over a coincident increment.
    if (err_clr) begin
      err_count_d = '0;
    end else if (out_xfer_c && out_err_q && (err_count_q != {CW{1'b1}})) begin
      err_count_d = err_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_onehot_codec_pipe.sv
// Directed bench for onehot_codec_pipe (W=3, CW=2); expectations follow ONEHOT_CODEC_STRICT_EN when defined.
module tb_onehot_codec_pipe;

  localparam int unsigned W  = 3;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_err;
  logic          err_clr;
  logic [CW-1:0] err_count;

  int n_total;
  int n_bad;
  int cyc;

  logic [N-1:0] got_data[$];
  logic         got_err[$];
  int           got_cyc[$];

  logic [N-1:0]  dec_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [N-1:0]  mix_exp [4] = '{8'h20, 8'h04, 8'h04, 8'h07};
  logic [N-1:0]  stl_exp [5] = '{8'h08, 8'h02, 8'h10, 8'h40, 8'h04};
  logic [CW-1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  onehot_codec_pipe #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_err.push_back(out_err);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clrq();
    got_data.delete();
    got_err.delete();
    got_cyc.delete();
  endtask

  // Offer one word from posedge+1 until accepted; returns at posedge+1 after the transfer edge.
  task automatic push(input logic mode, input logic [N-1:0] data);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("push_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    begin : dec_test
      int c0;
      clrq();
      c0 = cyc;
      for (int i = 0; i < 8; i++) push(1'b0, N'(i));
      repeat (5) @(posedge clk);
      #1;
      chk("dec_count", 32'(got_data.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
        if (i < got_data.size()) begin
          chk("dec_data", 32'(got_data[i]), 32'(dec_exp[i]));
          chk("dec_err",  32'(got_err[i]),  32'd0);
          chk("dec_cyc",  32'(got_cyc[i]),  32'(c0 + 2 + i));
        end
      end
    end

    clrq();
    for (int i = 0; i < 8; i++) push(1'b1, dec_exp[i]);
    repeat (5) @(posedge clk);
    #1;
    chk("enc_count", 32'(got_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_data.size()) begin
        chk("enc_data", 32'(got_data[i]), 32'(i));
        chk("enc_err",  32'(got_err[i]),  32'd0);
      end
    end
    chk("enc_err_count", 32'(err_count), 32'd0);

    clrq();
    push(1'b1, 8'h00);
    push(1'b1, 8'h24);
    repeat (5) @(posedge clk);
    #1;
    chk("bad_count", 32'(got_data.size()), 32'd2);
    if (got_data.size() == 2) begin
      chk("zero_data", 32'(got_data[0]), 32'd0);
      chk("zero_err",  32'(got_err[0]),  32'd1);
`ifdef ONEHOT_CODEC_STRICT_EN
      chk("multi_data", 32'(got_data[1]), 32'd0);
      chk("multi_err",  32'(got_err[1]),  32'd1);
`else
      chk("multi_data", 32'(got_data[1]), 32'd5);
      chk("multi_err",  32'(got_err[1]),  32'd0);
`endif
    end
`ifdef ONEHOT_CODEC_STRICT_EN
    chk("bad_err_count", 32'(err_count), 32'd2);
`else
    chk("bad_err_count", 32'(err_count), 32'd1);
`endif

    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("clr_count", 32'(err_count), 32'd0);

    clrq();
    push(1'b0, 8'h05);
    push(1'b1, 8'h10);
    push(1'b0, 8'h02);
    push(1'b1, 8'h80);
    repeat (5) @(posedge clk);
    #1;
    chk("mix_count", 32'(got_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_data.size()) begin
        chk("mix_data", 32'(got_data[i]), 32'(mix_exp[i]));
        chk("mix_err",  32'(got_err[i]),  32'd0);
      end
    end

    // Backpressure: out_ready low for the first four cycles of out_valid.
    clrq();
    out_ready = 1'b0;
    fork
      begin
        push(1'b0, 8'h03);
        push(1'b0, 8'h01);
        push(1'b0, 8'h04);
        push(1'b0, 8'h06);
        push(1'b0, 8'h02);
      end
      begin
        wait_ov("stall_ov_timeout");
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          chk("stall_valid",    32'(out_valid), 32'd1);
          chk("stall_data",     32'(out_data),  32'h08);
          chk("stall_in_ready", 32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("stall_count", 32'(got_data.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_data.size()) chk("stall_order", 32'(got_data[i]), 32'(stl_exp[i]));
    end

    for (int k = 0; k < 5; k++) begin
      push(1'b1, 8'h00);
      repeat (4) @(negedge clk);
      chk("sat_count", 32'(err_count), 32'(sat_exp[k]));
      @(posedge clk);
      #1;
    end
    push(1'b1, 8'h00);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(negedge clk);
    chk("clr_coinc_xfer", 32'(out_valid && out_err), 32'd1);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("clr_wins", 32'(err_count), 32'd0);

    push(1'b1, 8'h00);
    repeat (4) @(negedge clk);
    chk("pre_rst_count", 32'(err_count), 32'd1);
    @(posedge clk);
    #1;

    // Reset with two words in flight and the output stalled.
    clrq();
    out_ready = 1'b0;
    push(1'b1, 8'h00);
    push(1'b1, 8'h01);
    wait_ov("rst_ov_timeout");
    chk("rst_pre_stall", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",    32'(out_valid), 32'd0);
    chk("rst_mid_count",    32'(err_count), 32'd0);
    chk("rst_mid_data",     32'(out_data),  32'd0);
    chk("rst_mid_in_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_emit",    32'(got_data.size()), 32'd0);
    chk("rst_post_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
